// File: rtl/modem_tx_ctrl_if.sv
// rtl/modem_tx_ctrl_if.sv - SPI-core bus cycle interface for modem_tx_ctrl
interface modem_tx_ctrl_if #(
  parameter int ADDR_W = 10
) ();
  logic              spi_wr;
  logic              spi_rd;
  logic [ADDR_W-1:0] spi_addr;
  logic [7:0]        spi_wdata;
  logic [7:0]        spi_rdata;

  modport master (output spi_wr, spi_rd, spi_addr, spi_wdata, input spi_rdata);
  modport slave  (input spi_wr, spi_rd, spi_addr, spi_wdata, output spi_rdata);
endinterface

// File: rtl/modem_tx_ctrl.sv
// rtl/modem_tx_ctrl.sv - SPI register/RAM decode, TX slot queue and TX engine dispatch
// Optional IRQ output and IRQ_MASK register under MODEM_TX_IRQ_EN.
module modem_tx_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int RAM_DEPTH = 1000,
  parameter int LEN_W     = 10,
  parameter int NUM_BUF   = 2,
  parameter int SLOT_W    = 9,
  parameter int QDEPTH    = 4
) (
  input  logic              clk,
  input  logic              reset,
  modem_tx_ctrl_if.slave    spi,
  input  logic [7:0]        i_ram_rdata,
  output logic              o_ram_wr,
  output logic              o_ram_rd,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [7:0]        o_ram_wdata,
  output logic              o_tx_start,
  output logic [ADDR_W-1:0] o_tx_base,
  output logic [LEN_W-1:0]  o_tx_len,
  output logic              o_tx_abort,
  input  logic              i_tx_done
`ifdef MODEM_TX_IRQ_EN
  ,
  output logic              o_irq
`endif
);
  localparam int QW = $clog2(QDEPTH);
  localparam logic [ADDR_W-1:0] REG_BASE = ADDR_W'(RAM_DEPTH);
  localparam logic [31:0] SLOT_BYTES = 32'(1) << SLOT_W;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] START = 2'd2;
  localparam logic [1:0] BUSY  = 2'd3;

  logic [1:0]        r_state;
  logic [LEN_W-1:0]  r_len [NUM_BUF];
  logic [2:0]        r_q [QDEPTH];
  logic [QW-1:0]     r_wp, r_rp;
  logic [QW:0]       r_cnt;
  logic [2:0]        r_act;
  logic [ADDR_W-1:0] r_tx_base;
  logic [LEN_W-1:0]  r_tx_len;
  logic              r_abort, r_done, r_err, r_done_d, r_done_d2;

  logic              w_is_ram, w_reg_wr, w_ctrl_wr, w_stat_wr, w_go, w_abort_wr;
  logic              w_pop, w_push, w_go_bad, w_done_evt, w_busy;
  logic [ADDR_W-1:0] w_off;
  logic [31:0]       w_offi;
  logic [2:0]        w_slot;
  logic [LEN_W-1:0]  w_slot_len, w_head_len;
  logic [QW-1:0]     w_rel;
  logic [NUM_BUF-1:0] w_prot;
  logic [7:0]        w_rdata;

  assign w_is_ram   = spi.spi_addr < REG_BASE;
  assign w_off      = spi.spi_addr - REG_BASE;
  assign w_offi     = 32'(w_off);
  assign w_reg_wr   = spi.spi_wr && !w_is_ram;
  assign w_ctrl_wr  = w_reg_wr && (w_offi == 32'd2);
  assign w_stat_wr  = w_reg_wr && (w_offi == 32'd3);
  assign w_go       = w_ctrl_wr && spi.spi_wdata[0] && !spi.spi_wdata[7];
  assign w_abort_wr = w_ctrl_wr && spi.spi_wdata[7];
  assign w_slot     = spi.spi_wdata[3:1];
  assign w_busy     = (r_state != IDLE);
  assign w_done_evt = r_done_d && !r_done_d2;

  assign o_ram_wr    = spi.spi_wr && w_is_ram;
  assign o_ram_rd    = spi.spi_rd && w_is_ram;
  assign o_ram_addr  = spi.spi_addr;
  assign o_ram_wdata = spi.spi_wdata;
  assign o_tx_start  = (r_state == START) && !w_abort_wr;
  assign o_tx_base   = r_tx_base;
  assign o_tx_len    = r_tx_len;
  assign o_tx_abort  = r_abort;
  assign spi.spi_rdata = w_rdata;

  always_comb begin
    w_slot_len = '0;
    w_head_len = '0;
    for (int k = 0; k < NUM_BUF; k++) begin
      if (w_slot == 3'(k)) w_slot_len = r_len[k];
      if (r_q[r_rp] == 3'(k)) w_head_len = r_len[k];
    end
  end

  // A slot is locked while it is being sent or has any live queue entry.
  always_comb begin
    w_prot = '0;
    w_rel  = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      w_rel = QW'(i) - r_rp;
      for (int k = 0; k < NUM_BUF; k++)
        if (({1'b0, w_rel} < r_cnt) && (r_q[i] == 3'(k))) w_prot[k] = 1'b1;
    end
    for (int k = 0; k < NUM_BUF; k++)
      if ((r_state == START || r_state == BUSY) && r_act == 3'(k)) w_prot[k] = 1'b1;
  end

  assign w_pop    = (r_state == LOAD) && !w_abort_wr;
  assign w_go_bad = (32'(w_slot) >= 32'(NUM_BUF)) || (w_slot_len == '0) ||
                    (32'(w_slot_len) > SLOT_BYTES) ||
                    ((r_cnt == (QW+1)'(QDEPTH)) && !w_pop);
  assign w_push   = w_go && !w_go_bad;

  always_ff @(posedge clk) begin
    if (w_push && !w_abort_wr) r_q[r_wp] <= w_slot;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (w_abort_wr) begin
      r_rp  <= r_wp;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_act     <= '0;
      r_tx_base <= '0;
      r_tx_len  <= '0;
      r_abort   <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_done_d  <= 1'b0;
      r_done_d2 <= 1'b0;
    end else begin
      r_done_d  <= i_tx_done;
      r_done_d2 <= r_done_d;
      r_abort   <= 1'b0;
      if (w_stat_wr && spi.spi_wdata[1]) r_done <= 1'b0;
      if (w_stat_wr && spi.spi_wdata[2]) r_err  <= 1'b0;
      if (w_go && w_go_bad) r_err <= 1'b1;
      case (r_state)
        IDLE:  if (r_cnt != '0 && !w_abort_wr) r_state <= LOAD;
        LOAD:  begin
          if (w_abort_wr) r_state <= IDLE;
          else begin
            r_act     <= r_q[r_rp];
            r_tx_base <= ADDR_W'(32'(r_q[r_rp]) << SLOT_W);
            r_tx_len  <= w_head_len;
            r_state   <= START;
          end
        end
        START: r_state <= w_abort_wr ? IDLE : BUSY;
        default: begin
          // Done beats a same-cycle abort: the frame is complete, so no abort pulse.
          if (w_done_evt) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else if (w_abort_wr) begin
            r_abort <= 1'b1;
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_BUF; k++) r_len[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_BUF; k++) begin
        if (w_reg_wr && !w_prot[k] && w_offi == 32'(4 + 2*k))
          r_len[k][LEN_W-1:8] <= spi.spi_wdata[LEN_W-9:0];
        if (w_reg_wr && !w_prot[k] && w_offi == 32'(5 + 2*k))
          r_len[k][7:0] <= spi.spi_wdata;
      end
    end
  end

`ifdef MODEM_TX_IRQ_EN
  logic [2:1] r_mask;
  logic       r_irq;
  assign o_irq = r_irq;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask <= '0;
      r_irq  <= 1'b0;
    end else begin
      if (w_reg_wr && w_offi == 32'(4 + 2*NUM_BUF)) r_mask <= spi.spi_wdata[2:1];
      r_irq <= |({r_err, r_done} & r_mask);
    end
  end
`endif

  always_comb begin
    w_rdata = 8'h00;
    if (w_is_ram) w_rdata = i_ram_rdata;
    else begin
      if (w_offi == 32'd0) w_rdata = 8'h96;
      if (w_offi == 32'd1) w_rdata = 8'h02;
      if (w_offi == 32'd3) w_rdata = {1'b0, 3'(r_cnt), 1'b0, r_err, r_done, w_busy};
      for (int k = 0; k < NUM_BUF; k++) begin
        if (w_offi == 32'(4 + 2*k)) w_rdata = 8'(r_len[k] >> 8);
        if (w_offi == 32'(5 + 2*k)) w_rdata = r_len[k][7:0];
      end
`ifdef MODEM_TX_IRQ_EN
      if (w_offi == 32'(4 + 2*NUM_BUF)) w_rdata = {5'b0, r_mask, 1'b0};
`endif
    end
  end
endmodule
